midi_nrpn_param_writer: RTL
===========================

# midi_nrpn_param_writer

Front end of the synth engine parameter bus. Parses a decoded MIDI byte stream and converts NRPN Control Change sequences on one selectable channel into parameter-bus write transactions. Each transaction drives `adr`, `data`, one of `com_sel`/`osc_sel`/`m1_sel`/`m2_sel`, and an active-low `write` strobe. It is the initiator for the mixer and oscillator register files, which latch on the falling edge of `write`.

## Interface
- `SETUP_CYC`, default 2: cycles `adr`/`data`/sel are stable with `write` high before the strobe (min 1).
- `STROBE_CYC`, default 4: cycles `write` is held low (min 1).
- `HOLD_CYC`, default 2: cycles `adr`/`data`/sel are held after `write` returns high (min 1).
- `iCLK` in 1: single clock; all logic runs on its rising edge.
- `iRST` in 1: reset, synchronous, active-high.
- `iCH` in 4: MIDI channel to respond to (0-15).
- `byte_in` in 8: MIDI byte.
- `byte_valid` in 1: one-cycle qualifier for `byte_in`.
- `data` out 8: parameter value, `{1'b0, value7}`.
- `adr` out 7: parameter address.
- `write` out 1: active-low write strobe; idles high.
- `com_sel`, `osc_sel`, `m1_sel`, `m2_sel` out 1 each: bank selects; at most one is high.
- `busy` out 1: a transaction is in progress.
- `overflow` out 1: one-cycle pulse when an entry is dropped.

## Operation
- Parser FSM states: P_NONE (no running status), P_NUM (expect CC number), P_VAL (expect CC value), P_SKIP (foreign status; data bytes ignored).
  - Status `0xB0|iCH` -> P_NUM.
  - Any other channel status (0x80-0xEF) -> P_SKIP.
  - 0xF0-0xF7 -> P_NONE.
  - 0xF8-0xFF (real-time) are ignored with no state change, including mid-message.
  - Data byte (<0x80) in P_NUM: latch the CC number -> P_VAL.
  - Data byte in P_VAL: act on the CC pair -> P_NUM (running status).
  - Data bytes in P_NONE or P_SKIP are ignored.
- CC actions:
  - 0x63 (NRPN MSB): values 0-3 set `bank` (0 com, 1 osc, 2 m1, 3 m2) and clear `armed`. Value >3 clears `armed` and leaves `bank` unchanged.
  - 0x62 (NRPN LSB): set `nadr` = value. Set `armed` only if the last 0x63 value was valid (0-3).
  - 0x06 (data entry): if `armed`, create entry {`bank`, `nadr`, value}. If not armed, ignore.
  - All other CC numbers are ignored.
- Entry dispatch:
  - Writer idle: the entry starts a transaction on the next cycle.
  - Writer busy and pending slot empty: the entry is stored in the slot.
  - Writer busy and slot full: the entry is dropped and `overflow` pulses.
- Writer FSM states: W_IDLE, W_SETUP (SETUP_CYC cycles), W_STROBE (STROBE_CYC), W_HOLD (HOLD_CYC).
  - `adr`/`data`/sel are driven from entry into W_SETUP until the end of W_HOLD.
  - `write` is 0 only in W_STROBE.
  - On W_HOLD exit, sel drops. `adr`/`data` keep their last values.
  - If the slot is full on W_HOLD exit, the slot entry goes directly to W_SETUP with zero idle cycles. Otherwise -> W_IDLE.
- Entry width: 2-bit bank + 7-bit adr + 7-bit value. The MSB of `data` is always 0.

## Timing
- Reset values: `data`=0, `adr`=0, `write`=1, all sels 0, `busy`=0, `overflow`=0. Also reset: parser P_NONE, `bank`=0, `nadr`=0, `armed`=0, slot empty.
- `byte_valid` is ignored in any cycle where `iRST`=1.
- Data-entry value byte accepted at edge N:
  - sel/`adr`/`data`/`busy` valid from N+1.
  - `write` low from N+1+SETUP_CYC for STROBE_CYC cycles.
  - sel and `busy` low at N+1+SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - With defaults: write low N+3..N+6, idle at N+9. Transaction length T = SETUP+STROBE+HOLD = 8.
- `busy` stays high across back-to-back transactions.
- Simultaneous events:
  - An entry arriving on the W_HOLD exit cycle, with the slot full: the slot entry is dispatched and the new entry is stored. No overflow.
  - The same case with the slot empty: the new entry is dispatched directly.
- Reset mid-transaction: on the reset edge, `write` returns to 1 and sel drops in the same cycle. The transaction is abandoned and the slot is cleared.
- Byte throughput: one byte per cycle accepted. `byte_valid` is never back-pressured.

## Test plan
- Reset, `iCH`=3, bytes B3 63 01 62 12 06 40 -> `osc_sel`=1, `adr`=0x12, `data`=0x40. `write` low exactly 4 cycles starting 3 cycles after the 0x40 byte. Sel drops 9 cycles after the 0x40 byte.
- Running status: B0 63 00 62 01 06 20 06 21 (slot empty), `iCH`=0 -> two `com_sel` writes to `adr` 0x01 with data 0x20 then 0x21. The writes are back-to-back, `busy` is continuous, and there is no overflow.
- Three data entries inside one transaction -> the first two are written, the third raises one `overflow` pulse, and there are exactly 2 `write` falling edges.
- Channel and filtering:
  - B5 (`iCH`=3) -> no write.
  - 90 3C 7F interleaved with F8 inside a B3 message -> F8 does not break the message; the 90 message produces no write.
  - B3 63 07 62 05 06 10 -> no write (invalid bank).
- Data entry with no prior 0x62 after reset -> no write. Then 62 05 alone (bank defaults to 0, but `armed` requires a valid 0x63) -> still no write.
- Assert `iRST` during W_STROBE -> `write`=1 and sels=0 on the next edge, slot cleared, and no write after reset is released.

Source files
------------

// File: rtl/midi_nrpn_param_writer.sv
// midi_nrpn_param_writer
// Parses a decoded MIDI byte stream and turns NRPN Control Change sequences
// on one selectable channel into parameter-bus write transactions.
//
// Ports:
//   iCLK        clock, all logic on the rising edge
//   iRST        synchronous active-high reset
//   iCH         MIDI channel to respond to
//   byte_in     MIDI byte, qualified by byte_valid
//   byte_valid  one-cycle qualifier for byte_in
//   data        parameter value {1'b0, value7}
//   adr         parameter address
//   write       active-low write strobe, idles high
//   com_sel, osc_sel, m1_sel, m2_sel  bank selects (at most one high)
//   busy        a bus transaction is in progress
//   overflow    one-cycle pulse when an entry is dropped
module midi_nrpn_param_writer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [3:0] iCH,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] data,
  output logic [6:0] adr,
  output logic       write,
  output logic       com_sel,
  output logic       osc_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {P_NONE, P_NUM, P_VAL, P_SKIP} parserState_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} writerState_t;

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  parserState_t r_parserState, w_parserNext;
  writerState_t r_writerState, w_writerNext;

  logic [6:0] r_ccNum;
  logic [1:0] r_bank;
  logic [6:0] r_nadr;
  logic       r_armed;
  logic       r_msbValid;

  logic [7:0] r_cnt;

  logic [6:0] r_adr;
  logic [6:0] r_val;
  logic [3:0] r_sel;
  logic       r_overflow;

  logic       r_slotFull;
  logic [1:0] r_slotBank;
  logic [6:0] r_slotAdr;
  logic [6:0] r_slotVal;

  logic w_isCcPair;
  logic w_entryValid;
  logic w_loadNew;
  logic w_loadSlot;
  logic w_holdExit;

  // Parser next state. Real-time bytes (F8-FF) are transparent and never
  // disturb running status; a data byte in P_VAL completes a CC pair.
  always_comb begin
    w_parserNext = r_parserState;
    w_isCcPair   = 1'b0;
    if (byte_valid && (byte_in[7:3] != 5'b11111)) begin
      if (byte_in[7:4] == 4'hF) begin
        w_parserNext = P_NONE;
      end else if (byte_in[7]) begin
        w_parserNext = (byte_in == {4'hB, iCH}) ? P_NUM : P_SKIP;
      end else begin
        case (r_parserState)
          P_NUM: w_parserNext = P_VAL;
          P_VAL: begin
            w_parserNext = P_NUM;
            w_isCcPair   = 1'b1;
          end
          default: w_parserNext = r_parserState;
        endcase
      end
    end
  end

  // Parser state plus the NRPN context. armed only comes up after a 0x62
  // that follows a valid 0x63, so a stray 0x62 can never enable writes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_parserState <= P_NONE;
      r_ccNum       <= '0;
      r_bank        <= '0;
      r_nadr        <= '0;
      r_armed       <= 1'b0;
      r_msbValid    <= 1'b0;
    end else begin
      r_parserState <= w_parserNext;
      if (byte_valid && !byte_in[7] && (r_parserState == P_NUM)) begin
        r_ccNum <= byte_in[6:0];
      end
      if (w_isCcPair) begin
        case (r_ccNum)
          7'h63: begin
            r_armed <= 1'b0;
            if (byte_in[6:2] == 5'd0) begin
              r_bank     <= byte_in[1:0];
              r_msbValid <= 1'b1;
            end else begin
              r_msbValid <= 1'b0;
            end
          end
          7'h62: begin
            r_nadr <= byte_in[6:0];
            if (r_msbValid) begin
              r_armed <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_entryValid = w_isCcPair && (r_ccNum == 7'h06) && r_armed;

  // Writer next state. At the end of W_HOLD a waiting slot entry has priority
  // over a freshly arriving one so ordering is preserved with no idle gap.
  always_comb begin
    w_writerNext = r_writerState;
    w_loadNew    = 1'b0;
    w_loadSlot   = 1'b0;
    w_holdExit   = 1'b0;
    case (r_writerState)
      W_IDLE: begin
        if (w_entryValid) begin
          w_writerNext = W_SETUP;
          w_loadNew    = 1'b1;
        end
      end
      W_SETUP: begin
        if (r_cnt == SETUP_LAST) w_writerNext = W_STROBE;
      end
      W_STROBE: begin
        if (r_cnt == STROBE_LAST) w_writerNext = W_HOLD;
      end
      W_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_holdExit = 1'b1;
          if (r_slotFull) begin
            w_writerNext = W_SETUP;
            w_loadSlot   = 1'b1;
          end else if (w_entryValid) begin
            w_writerNext = W_SETUP;
            w_loadNew    = 1'b1;
          end else begin
            w_writerNext = W_IDLE;
          end
        end
      end
      default: w_writerNext = W_IDLE;
    endcase
  end

  // Writer state register; the phase counter restarts on every state change.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_writerState <= W_IDLE;
      r_cnt         <= '0;
    end else begin
      r_writerState <= w_writerNext;
      if ((w_writerNext != r_writerState) || (r_writerState == W_IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Bus datapath and the single pending slot. adr/data keep their last
  // values after a transaction; only the select drops.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_adr      <= '0;
      r_val      <= '0;
      r_sel      <= '0;
      r_overflow <= 1'b0;
      r_slotFull <= 1'b0;
      r_slotBank <= '0;
      r_slotAdr  <= '0;
      r_slotVal  <= '0;
    end else begin
      r_overflow <= 1'b0;
      if (w_loadSlot) begin
        r_adr      <= r_slotAdr;
        r_val      <= r_slotVal;
        r_sel      <= 4'b0001 << r_slotBank;
        r_slotFull <= w_entryValid;
        if (w_entryValid) begin
          r_slotBank <= r_bank;
          r_slotAdr  <= r_nadr;
          r_slotVal  <= byte_in[6:0];
        end
      end else if (w_loadNew) begin
        r_adr <= r_nadr;
        r_val <= byte_in[6:0];
        r_sel <= 4'b0001 << r_bank;
      end else begin
        if (w_holdExit) r_sel <= '0;
        if (w_entryValid) begin
          if (!r_slotFull) begin
            r_slotFull <= 1'b1;
            r_slotBank <= r_bank;
            r_slotAdr  <= r_nadr;
            r_slotVal  <= byte_in[6:0];
          end else begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign data     = {1'b0, r_val};
  assign adr      = r_adr;
  assign write    = (r_writerState != W_STROBE);
  assign com_sel  = r_sel[0];
  assign osc_sel  = r_sel[1];
  assign m1_sel   = r_sel[2];
  assign m2_sel   = r_sel[3];
  assign busy     = (r_writerState != W_IDLE);
  assign overflow = r_overflow;

endmodule
